// File: rtl/wr_data_stage_fifo_pkg.sv
// rtl/wr_data_stage_fifo_pkg.sv - shared types and constants for the write-data staging FIFO
package wr_data_stage_fifo_pkg;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } wstate_e;

    // Entry layout: {last, strb[3:0], data[31:0]}
    localparam int WDATA_ENTRY_W = 37;
    localparam logic [1:0] WERR_OK = 2'b00;

endpackage

// File: rtl/wdata_sync_fifo_core.sv
// rtl/wdata_sync_fifo_core.sv - show-ahead synchronous FIFO with wrap-bit pointers
module wdata_sync_fifo_core #(
    parameter int WIDTH = 37,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // Cleared so the show-ahead outputs read zero straight out of reset
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/wr_data_stage_fifo.sv
// rtl/wr_data_stage_fifo.sv - AHB-to-memory write-data staging buffer with burst tracking
module wr_data_stage_fifo
    import wr_data_stage_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  mem_clk,
    input  logic                  reset,
    input  logic                  ahb_wdata_valid,
    input  logic [31:0]           ahb_wdata,
    input  logic [3:0]            ahb_wstrb,
    input  logic                  ahb_wlast,
    output logic                  ahb_wdata_ready,
    output logic                  slv_mem_wdata_valid,
    output logic [31:0]           slv_mem_wdata,
    output logic [3:0]            slv_mem_wstrb,
    output logic                  slv_mem_wlast,
    input  logic                  slv_mem_wdata_ack,
    input  logic [1:0]            slv_mem_wdata_err,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  burst_avail,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  wr_err_sticky,
    output logic [1:0]            wr_err_code,
    input  logic                  err_clr
);

    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    wstate_e                  state;
    wstate_e                  state_nxt;
    logic [WDATA_ENTRY_W-1:0] wr_entry;
    logic [WDATA_ENTRY_W-1:0] head_entry;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     clear;
    logic                     err_evt;
    logic                     ready_en;
    logic                     head_last;
    logic [DEPTH_LOG2:0]      bursts_pending;

    assign wr_entry      = {ahb_wlast, ahb_wstrb, ahb_wdata};
    assign head_last     = head_entry[WDATA_ENTRY_W-1];
    assign slv_mem_wlast = head_last;
    assign slv_mem_wstrb = head_entry[35:32];
    assign slv_mem_wdata = head_entry[31:0];
    assign flush_done    = (state == ST_FLUSH);
    assign burst_avail   = (bursts_pending != '0);

    wdata_sync_fifo_core #(
        .WIDTH (WDATA_ENTRY_W),
        .AW    (DEPTH_LOG2)
    ) u_core (
        .clk     (mem_clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_comb begin
        ahb_wdata_ready     = ready_en && !full && (state != ST_FLUSH) && !flush_req;
        slv_mem_wdata_valid = !empty && (state == ST_PASS);
        push                = ahb_wdata_valid && ahb_wdata_ready;
        pop                 = 1'b0;
        err_evt             = 1'b0;
        clear               = flush_req || (state == ST_FLUSH);
        state_nxt           = state;
        // Flush outranks everything: the ack of this cycle is ignored
        if (flush_req) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_PASS: begin
                    pop     = slv_mem_wdata_valid && slv_mem_wdata_ack;
                    err_evt = pop && (slv_mem_wdata_err != WERR_OK);
                    if (err_evt && !head_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pop = !empty;
                    if (pop && head_last) begin
                        state_nxt = ST_PASS;
                    end
                end
                default: state_nxt = ST_PASS;
            endcase
        end
    end

    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state          <= ST_PASS;
            ready_en       <= 1'b0;
            bursts_pending <= '0;
            wr_err_sticky  <= 1'b0;
            wr_err_code    <= WERR_OK;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (clear) begin
                bursts_pending <= '0;
            end else begin
                case ({push && ahb_wlast, pop && head_last})
                    2'b10:   bursts_pending <= bursts_pending + CNT_ONE;
                    2'b01:   bursts_pending <= bursts_pending - CNT_ONE;
                    default: bursts_pending <= bursts_pending;
                endcase
            end
            // A fresh error beats a same-cycle clear; otherwise the first code sticks
            if (err_evt && (!wr_err_sticky || err_clr)) begin
                wr_err_sticky <= 1'b1;
                wr_err_code   <= slv_mem_wdata_err;
            end else if (err_clr) begin
                wr_err_sticky <= 1'b0;
                wr_err_code   <= WERR_OK;
            end
        end
    end

endmodule

// File: tb/tb_wr_data_stage_fifo.sv
// tb/tb_wr_data_stage_fifo.sv - queue-model bench for the write-data staging FIFO
module tb_wr_data_stage_fifo;

    localparam int DL    = 3;
    localparam int DEPTH = 8;

    logic        mem_clk = 1'b0;
    logic        reset = 1'b1;
    logic        ahb_wdata_valid = 1'b0;
    logic [31:0] ahb_wdata = '0;
    logic [3:0]  ahb_wstrb = '0;
    logic        ahb_wlast = 1'b0;
    logic        ahb_wdata_ready;
    logic        slv_mem_wdata_valid;
    logic [31:0] slv_mem_wdata;
    logic [3:0]  slv_mem_wstrb;
    logic        slv_mem_wlast;
    logic        slv_mem_wdata_ack = 1'b0;
    logic [1:0]  slv_mem_wdata_err = '0;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic        burst_avail;
    logic [DL:0] fifo_level;
    logic        wr_err_sticky;
    logic [1:0]  wr_err_code;
    logic        err_clr = 1'b0;

    always #5 mem_clk = ~mem_clk;

    wr_data_stage_fifo #(.DEPTH_LOG2(DL)) dut (
        .mem_clk             (mem_clk),
        .reset               (reset),
        .ahb_wdata_valid     (ahb_wdata_valid),
        .ahb_wdata           (ahb_wdata),
        .ahb_wstrb           (ahb_wstrb),
        .ahb_wlast           (ahb_wlast),
        .ahb_wdata_ready     (ahb_wdata_ready),
        .slv_mem_wdata_valid (slv_mem_wdata_valid),
        .slv_mem_wdata       (slv_mem_wdata),
        .slv_mem_wstrb       (slv_mem_wstrb),
        .slv_mem_wlast       (slv_mem_wlast),
        .slv_mem_wdata_ack   (slv_mem_wdata_ack),
        .slv_mem_wdata_err   (slv_mem_wdata_err),
        .flush_req           (flush_req),
        .flush_done          (flush_done),
        .burst_avail         (burst_avail),
        .fifo_level          (fifo_level),
        .wr_err_sticky       (wr_err_sticky),
        .wr_err_code         (wr_err_code),
        .err_clr             (err_clr)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {last,strb,data} plus a few mode flags
    bit [36:0] q[$];
    bit        m_drain, m_flush, m_sticky, m_rdy, started;
    bit [1:0]  m_code;

    function automatic int n_last();
        int c = 0;
        foreach (q[i]) if (q[i][36]) c++;
        return c;
    endfunction

    function automatic bit m_ready();
        return m_rdy && (q.size() < DEPTH) && !m_flush && !flush_req;
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) && !m_drain && !m_flush;
    endfunction

    always @(posedge mem_clk) begin
        bit pu, po, ev, hl;
        if (reset) begin
            q.delete();
            m_drain = 0; m_flush = 0; m_sticky = 0; m_code = 0; m_rdy = 0;
            started = 1;
        end else if (started) begin
            pu = ahb_wdata_valid && m_ready();
            ev = 0;
            if (flush_req) begin
                q.delete();
                m_flush = 1;
                m_drain = 0;
            end else if (m_flush) begin
                m_flush = 0;
            end else begin
                hl = (q.size() > 0) && q[0][36];
                po = m_drain ? (q.size() > 0) : (m_valid() && slv_mem_wdata_ack);
                ev = !m_drain && po && (slv_mem_wdata_err != 2'b00);
                if (po) begin
                    void'(q.pop_front());
                    if (m_drain && hl) m_drain = 0;
                    else if (ev && !hl) m_drain = 1;
                end
                if (pu) q.push_back({ahb_wlast, ahb_wstrb, ahb_wdata});
            end
            if (ev && (!m_sticky || err_clr)) begin
                m_sticky = 1;
                m_code   = slv_mem_wdata_err;
            end else if (err_clr) begin
                m_sticky = 0;
                m_code   = 0;
            end
            m_rdy = 1;
        end
    end

    always @(negedge mem_clk) begin
        if (started) begin
            chk("ready", ahb_wdata_ready, m_ready());
            chk("valid", slv_mem_wdata_valid, m_valid());
            chk("level", fifo_level, q.size());
            chk("burst_avail", burst_avail, n_last() > 0);
            chk("flush_done", flush_done, m_flush);
            chk("sticky", wr_err_sticky, m_sticky);
            chk("code", wr_err_code, m_code);
            if (q.size() > 0)
                chk("head", {slv_mem_wlast, slv_mem_wstrb, slv_mem_wdata}, q[0]);
        end
    end

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        ahb_wdata_valid = 1; ahb_wdata = d; ahb_wstrb = 4'hF; ahb_wlast = l;
        step();
    endtask

    initial begin
        repeat (2) step();
        reset = 0;
        step();
        @(negedge mem_clk);
        chk("lit_ready_after_reset", ahb_wdata_ready, 1);
        step();

        // One 4-beat burst with ack held high
        slv_mem_wdata_ack = 1;
        for (int i = 0; i < 4; i++) beat(32'h1111_1111 * (i + 1), i == 3);
        ahb_wdata_valid = 0;
        @(negedge mem_clk);
        chk("lit_burst_avail_rise", burst_avail, 1);
        chk("lit_beat4_last", slv_mem_wlast, 1);
        chk("lit_beat4_data", slv_mem_wdata, 32'h4444_4444);
        step();
        slv_mem_wdata_ack = 0;
        @(negedge mem_clk);
        chk("lit_level_empty", fifo_level, 0);
        chk("lit_burst_avail_fall", burst_avail, 0);
        step();

        // Fill to full, no pass-through on the freeing ack
        for (int i = 0; i < 8; i++) beat(32'hC000_0000 + i, (i % 4) == 3);
        @(negedge mem_clk);
        chk("lit_full_ready", ahb_wdata_ready, 0);
        chk("lit_full_level", fifo_level, 8);
        step();
        slv_mem_wdata_ack = 1;
        step();
        slv_mem_wdata_ack = 0; ahb_wdata_valid = 0;
        @(negedge mem_clk);
        chk("lit_ready_back", ahb_wdata_ready, 1);
        chk("lit_level_7", fifo_level, 7);
        slv_mem_wdata_ack = 1;
        repeat (7) step();
        slv_mem_wdata_ack = 0;
        @(negedge mem_clk);
        chk("lit_drained", fifo_level, 0);
        step();

        // Error mid-burst drains the rest of burst 1
        for (int i = 0; i < 4; i++) beat(32'hA000_0000 + i, i == 3);
        for (int i = 0; i < 4; i++) beat(32'hB000_0000 + i, i == 3);
        ahb_wdata_valid = 0;
        slv_mem_wdata_ack = 1;
        step();
        slv_mem_wdata_err = 2'b10;
        step();
        slv_mem_wdata_ack = 0; slv_mem_wdata_err = 0;
        @(negedge mem_clk);
        chk("lit_drain_valid", slv_mem_wdata_valid, 0);
        chk("lit_drain_level", fifo_level, 6);
        repeat (2) step();
        @(negedge mem_clk);
        chk("lit_b0_valid", slv_mem_wdata_valid, 1);
        chk("lit_b0_data", slv_mem_wdata, 32'hB000_0000);
        chk("lit_sticky", wr_err_sticky, 1);
        chk("lit_code_10", wr_err_code, 2'b10);
        chk("lit_one_burst", burst_avail, 1);
        chk("lit_level_4", fifo_level, 4);

        // Error on a last beat keeps PASS and the first code
        slv_mem_wdata_ack = 1;
        repeat (3) step();
        slv_mem_wdata_err = 2'b01;
        step();
        slv_mem_wdata_ack = 0; slv_mem_wdata_err = 0;
        @(negedge mem_clk);
        chk("lit_code_kept", wr_err_code, 2'b10);
        beat(32'hD000_0000, 0);
        ahb_wdata_valid = 0;
        @(negedge mem_clk);
        chk("lit_still_pass", slv_mem_wdata_valid, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        @(negedge mem_clk);
        chk("lit_clr_sticky", wr_err_sticky, 0);
        chk("lit_clr_code", wr_err_code, 0);

        // Flush while a beat is offered
        for (int i = 0; i < 5; i++) beat(32'hE000_0000 + i, i == 3);
        flush_req = 1;
        @(negedge mem_clk);
        chk("lit_flush_ready0", ahb_wdata_ready, 0);
        step();
        flush_req = 0;
        @(negedge mem_clk);
        chk("lit_flush_ready1", ahb_wdata_ready, 0);
        chk("lit_flush_done", flush_done, 1);
        chk("lit_flush_level", fifo_level, 0);
        step();
        ahb_wdata_valid = 0;
        @(negedge mem_clk);
        chk("lit_flush_done_once", flush_done, 0);
        chk("lit_flush_avail", burst_avail, 0);
        step();

        // Reset with content buffered
        for (int i = 0; i < 3; i++) beat(32'hF000_0000 + i, 0);
        ahb_wdata_valid = 0;
        reset = 1;
        step();
        @(negedge mem_clk);
        chk("lit_rst_valid", slv_mem_wdata_valid, 0);
        chk("lit_rst_ready", ahb_wdata_ready, 0);
        chk("lit_rst_level", fifo_level, 0);
        chk("lit_rst_flush_done", flush_done, 0);
        chk("lit_rst_data", {slv_mem_wlast, slv_mem_wstrb, slv_mem_wdata}, 0);
        reset = 0;
        step();
        @(negedge mem_clk);
        chk("lit_rst_ready_back", ahb_wdata_ready, 1);
        step();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ahb_wdata_valid   = ($urandom_range(0, 9) < 7);
            ahb_wdata         = $urandom;
            ahb_wstrb         = 4'($urandom_range(0, 15));
            ahb_wlast         = ($urandom_range(0, 3) == 0);
            slv_mem_wdata_ack = $urandom_range(0, 1);
            slv_mem_wdata_err = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            flush_req         = ($urandom_range(0, 99) == 0);
            err_clr           = ($urandom_range(0, 49) == 0);
            reset             = ($urandom_range(0, 499) == 0);
            step();
        end
        ahb_wdata_valid = 0; slv_mem_wdata_ack = 0; slv_mem_wdata_err = 0;
        flush_req = 0; err_clr = 0; reset = 0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/wr_data_stage_fifo.md
Name: wr_data_stage_fifo

Overview:
- Write-data staging buffer directly upstream of the memory interface controller's write-data port (slv_mem_wdata_*).
- Accepts 32-bit write beats from the AHB slave controller and stores them in a show-ahead FIFO.
- Presents the beats to the memory controller with a valid/ack handshake.
- Tracks complete bursts so the main controller only starts a memory write once a full burst is buffered.
- On a per-beat memory error, discards the remainder of the failing burst.

Parameters:
- DEPTH_LOG2, 3, log2 of the FIFO depth (default 8 entries). Legal range 2..6.

Ports:
- mem_clk  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset.
- ahb_wdata_valid  in  1  AHB side: beat offered.
- ahb_wdata  in  32  AHB side: beat data.
- ahb_wstrb  in  4  AHB side: byte strobes.
- ahb_wlast  in  1  AHB side: last beat of the burst.
- ahb_wdata_ready  out  1  beat accepted when valid&&ready.
- slv_mem_wdata_valid  out  1  beat presented to the memory controller.
- slv_mem_wdata  out  32  head-entry data.
- slv_mem_wstrb  out  4  head-entry strobes.
- slv_mem_wlast  out  1  head-entry last flag.
- slv_mem_wdata_ack  in  1  memory controller consumed the head beat.
- slv_mem_wdata_err  in  2  error code, qualified by ack; 2'b00 = OK.
- flush_req  in  1  one-cycle pulse: discard all content (transfer abort).
- flush_done  out  1  one-cycle pulse when the flush completes.
- burst_avail  out  1  at least one complete burst is buffered.
- fifo_level  out  DEPTH_LOG2+1  current number of entries.
- wr_err_sticky  out  1  an error has been seen since the last clear.
- wr_err_code  out  2  code of the first error since the last clear.
- err_clr  in  1  clears wr_err_sticky and wr_err_code.

Behaviour:
- Reset: pointers 0, fifo_level 0, bursts_pending 0, state PASS. All outputs 0: valid, ready, flush_done, burst_avail, sticky, code, data/strb/last. Ready rises the cycle after reset is released.
- Storage:
  - Entry is {last, strb[3:0], data[31:0]}, held in a register array.
  - Read is show-ahead: slv_mem_* data, strobe and last come combinationally from the rd_ptr entry.
  - Pointers are DEPTH_LOG2+1 bits with a wrap bit. full = MSBs differ and LSBs equal; empty = pointers equal.
- push = ahb_wdata_valid && ahb_wdata_ready.
  - ahb_wdata_ready = !full && state!=FLUSH && !flush_req.
  - There is no pass-through when full: a simultaneous pop does not enable a push in that cycle.
- pop:
  - PASS: pop = slv_mem_wdata_valid && slv_mem_wdata_ack, with slv_mem_wdata_valid = !empty && state==PASS.
  - DRAIN: pop = !empty (one entry per cycle, silent).
- fifo_level = level + push - pop; simultaneous push and pop leaves it unchanged.
- bursts_pending (DEPTH_LOG2+1 bits):
  - +1 on a push with wlast; -1 on a pop of a last entry, in either PASS or DRAIN.
  - Both in the same cycle leaves it unchanged.
  - burst_avail = bursts_pending!=0.
- FSM states PASS, DRAIN, FLUSH:
  - PASS to DRAIN: ack with err!=0 on a head entry whose last=0.
  - PASS stays PASS: ack with err!=0 and last=1 (burst already finished).
  - DRAIN to PASS: the cycle a last entry is popped. While DRAIN and empty, wait; slv_mem_wdata_valid stays 0.
  - Any state to FLUSH: flush_req=1. This has priority over push, pop and error. Pop is suppressed in the flush_req cycle.
  - FLUSH: pointers, level and bursts_pending cleared; flush_done=1 for that one cycle; next state PASS. Error status is kept.
- Error capture:
  - On ack with err!=0 while !wr_err_sticky: sticky<=1, code<=err.
  - Later errors do not overwrite the code.
  - err_clr clears both registers; an error in the same cycle wins (it sets them).
- reset mid-burst: all content is lost; no flush_done pulse is generated.

Decomposition:
- Shared package holds:
  - state encoding: PASS=2'd0, DRAIN=2'd1, FLUSH=2'd2;
  - WDATA_ENTRY_W=37;
  - the WERR_OK=2'b00 constant.
- One natural sub-module, wdata_sync_fifo_core: pointer, full/empty and level logic plus the register array, parameterised on width and depth.
- The FSM and burst accounting stay in the top.

Test Plan:
- Push 4 beats (data 0x11111111..0x44444444, strb 4'hF, last on beat 4) with ack held high. Expect:
  - burst_avail rises the cycle after the 4th push;
  - 4 beats emitted in order, slv_mem_wlast on beat 4;
  - level returns to 0; burst_avail returns to 0.
- Push 8 beats, no ack. Expect ready=0 and level=8; a 9th valid is not accepted. One ack brings ready back to 1 the next cycle; level goes 8 -> 7.
- Two 4-beat bursts buffered; ack beat 2 of burst 1 with err=2'b10. Expect:
  - beats 3-4 popped silently in DRAIN (valid=0);
  - burst 2 beat 1 presented afterwards;
  - sticky=1, code=2'b10, bursts_pending=1.
- After the previous case, error err=2'b01 on a last beat. Expect the state to stay PASS and code to remain 2'b10. Then err_clr gives sticky=0, code=0.
- 5 beats buffered, flush_req pulse while ahb_wdata_valid=1. Expect:
  - push dropped, ready=0 for 2 cycles;
  - flush_done high exactly 1 cycle;
  - level=0, burst_avail=0.
- Synchronous reset asserted with 3 beats buffered. Expect all outputs 0 in the next cycle, no flush_done, and ready=1 in the cycle after reset is released.
